// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter onto one shared single-port memory (round-robin on conflict with MEM_ARB_RR_EN)
module mem_port_arbiter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [DATA_WIDTH-1:0] i_addr,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [DATA_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    input  logic [2:0]            d_size,
    input  logic                  flush_i,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [2:0]            mem_size,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  i_ack,
    output logic                  d_ack,
    output logic [DATA_WIDTH-1:0] i_rdata,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  i_stall,
    output logic                  d_stall
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t state, state_nxt;
    logic   owner_d;
    logic   i_kill;
    logic   i_elig;
    logic   grant_valid;
    logic   grant_d;

    // A fetch is not eligible in a flush cycle: its address is already stale.
    assign i_elig      = i_req & ~flush_i;
    assign grant_valid = i_elig | d_req;

`ifdef MEM_ARB_RR_EN
    logic last_grant_d;

    assign grant_d = d_req & (~i_elig | ~last_grant_d);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_d <= 1'b0;
        end else if (state == IDLE && grant_valid) begin
            last_grant_d <= grant_d;
        end
    end
`else
    assign grant_d = d_req;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_valid) state_nxt = BUSY;
            BUSY:    if (mem_ack) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_d   <= 1'b0;
            i_kill    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_size  <= 3'b000;
            i_rdata   <= '0;
            d_rdata   <= '0;
        end else begin
            if (state == IDLE && grant_valid) begin
                owner_d   <= grant_d;
                i_kill    <= 1'b0;
                mem_we    <= grant_d ? d_we : 1'b0;
                mem_addr  <= grant_d ? d_addr : i_addr;
                mem_wdata <= grant_d ? d_wdata : '0;
                mem_size  <= grant_d ? d_size : 3'b010;
            end
            // A flushed fetch still finishes on the bus but its result is dropped.
            if (state == BUSY) begin
                if (!owner_d && flush_i) begin
                    i_kill <= 1'b1;
                end
                if (mem_ack) begin
                    if (owner_d) begin
                        d_rdata <= mem_rdata;
                    end else if (!i_kill && !flush_i) begin
                        i_rdata <= mem_rdata;
                    end
                end
            end
        end
    end

    always_comb begin
        mem_req = (state == BUSY);
        i_ack   = (state == RESP) & ~owner_d & ~i_kill & ~flush_i;
        d_ack   = (state == RESP) & owner_d;
    end

    assign i_stall = i_req & ~i_ack;
    assign d_stall = d_req & ~d_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized transaction-level bench for mem_port_arbiter
module tb_mem_port_arbiter;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, flush_i = 1'b0, mem_ack = 1'b0;
    logic [DW-1:0] i_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
    logic [2:0]    d_size = 3'b000;
    logic          mem_req, mem_we, i_ack, d_ack, i_stall, d_stall;
    logic [DW-1:0] mem_addr, mem_wdata, i_rdata, d_rdata;
    logic [2:0]    mem_size;

    mem_port_arbiter #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
        .flush_i(flush_i),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_size(mem_size), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .i_ack(i_ack), .d_ack(d_ack), .i_rdata(i_rdata), .d_rdata(d_rdata),
        .i_stall(i_stall), .d_stall(d_stall)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Transaction-level model: pending requests, last winner, expected read data.
    bit            pend_i, pend_d, last_d, d_we_m;
    logic [DW-1:0] ia_m, da_m, dw_m, exp_ir, exp_dr;
    logic [2:0]    dsz_m;
    int            n_d_grants, n_i_grants;

    task automatic run_random(input int n);
        bit            win_d, ack_kill, rd_kill;
        int            waits, fmode, fcyc;
        logic [DW-1:0] rd;
        logic [DW-1:0] exp_addr;
        for (int it = 0; it < n; it++) begin
            @(negedge clk);
            if (!pend_i && $urandom_range(0, 1) == 1) begin
                pend_i = 1; ia_m = $urandom;
            end
            if (!pend_d && $urandom_range(0, 1) == 1) begin
                pend_d = 1; da_m = $urandom; dw_m = $urandom;
                d_we_m = 1'($urandom_range(0, 1)); dsz_m = 3'($urandom_range(0, 7));
            end
            if (!pend_i && !pend_d) begin
                pend_i = 1; ia_m = $urandom;
            end
            i_req = pend_i; i_addr = ia_m;
            d_req = pend_d; d_addr = da_m; d_wdata = dw_m; d_we = d_we_m; d_size = dsz_m;
`ifdef MEM_ARB_RR_EN
            win_d = (pend_i && pend_d) ? !last_d : pend_d;
`else
            win_d = pend_d;
`endif
            last_d = win_d;
            if (win_d) n_d_grants++; else n_i_grants++;
            exp_addr = win_d ? da_m : ia_m;

            @(posedge clk); @(negedge clk);
            check("grant_mem_req", mem_req, 1);
            check("grant_mem_we", mem_we, win_d ? d_we_m : 1'b0);
            check("grant_mem_addr", mem_addr, exp_addr);
            check("grant_mem_size", mem_size, win_d ? dsz_m : 3'b010);
            if (win_d) check("grant_mem_wdata", mem_wdata, dw_m);

            waits = $urandom_range(0, 3);
            fmode = $urandom_range(0, 3);
            fcyc  = $urandom_range(0, waits);
            ack_kill = 0; rd_kill = 0; rd = '0;
            for (int w = 0; w <= waits; w++) begin
                if (w > 0) begin
                    check("busy_mem_req", mem_req, 1);
                    check("busy_mem_addr", mem_addr, exp_addr);
                    check("busy_no_ack", {i_ack, d_ack}, 2'b00);
                end
                if (fmode == 1 && w == fcyc) begin
                    flush_i = 1;
                    if (!win_d) begin ack_kill = 1; rd_kill = 1; end
                end
                if (w == waits) begin
                    rd = $urandom; mem_ack = 1; mem_rdata = rd;
                end
                @(posedge clk); @(negedge clk);
                flush_i = 0; mem_ack = 0;
            end

            check("resp_mem_req", mem_req, 0);
            if (fmode == 2) begin
                flush_i = 1;
                if (!win_d) ack_kill = 1;
                #1;
            end
            if (win_d) exp_dr = rd;
            else if (!rd_kill) exp_ir = rd;
            check("resp_i_ack", i_ack, !win_d && !ack_kill);
            check("resp_d_ack", d_ack, win_d);
            check("resp_i_rdata", i_rdata, exp_ir);
            check("resp_d_rdata", d_rdata, exp_dr);
            check("resp_i_stall", i_stall, pend_i && !(!win_d && !ack_kill));
            check("resp_d_stall", d_stall, pend_d && !win_d);
            flush_i = 0;
            if (win_d) pend_d = 0; else pend_i = 0;
            i_req = pend_i; d_req = pend_d;
            @(posedge clk);
            #1;
            check("post_resp_acks", {i_ack, d_ack}, 2'b00);
        end
    endtask

    initial begin
        pend_i = 0; pend_d = 0; last_d = 0; exp_ir = '0; exp_dr = '0;
        ia_m = '0; da_m = '0; dw_m = '0; d_we_m = 0; dsz_m = '0;
        n_d_grants = 0; n_i_grants = 0;
        rst = 1;
        @(posedge clk); @(posedge clk); @(negedge clk);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_fields", {mem_we, mem_size, mem_addr, mem_wdata}, '0);
        check("rst_acks", {i_ack, d_ack}, 2'b00);
        check("rst_rdata", {i_rdata, d_rdata}, '0);
        rst = 0;

        // Flush in IDLE blocks the fetch grant.
        @(negedge clk);
        i_req = 1; i_addr = 32'h104; flush_i = 1;
        @(posedge clk); @(negedge clk);
        check("idle_flush_no_grant", mem_req, 0);
        check("idle_flush_stall", i_stall, 1);
        i_req = 0; flush_i = 0;

        // Stray mem_ack in IDLE.
        @(negedge clk);
        mem_ack = 1; mem_rdata = 32'hCAFEF00D;
        @(posedge clk); @(negedge clk);
        mem_ack = 0;
        check("stray_ack_mem_req", mem_req, 0);
        check("stray_ack_acks", {i_ack, d_ack}, 2'b00);
        @(posedge clk); #1;
        check("stray_ack_acks2", {i_ack, d_ack}, 2'b00);
        check("stray_ack_rdata", {i_rdata, d_rdata}, '0);

        run_random(60);

        // Asynchronous reset in the middle of a fetch.
        @(negedge clk);
        i_req = 1; i_addr = 32'h104;
        @(posedge clk); @(negedge clk);
        check("pre_rst_mem_req", mem_req, 1);
        #2 rst = 1;
        #1;
        check("async_rst_mem_req", mem_req, 0);
        check("async_rst_mem_addr", mem_addr, 0);
        check("async_rst_rdata", {i_rdata, d_rdata}, '0);
        i_req = 0;
        @(negedge clk);
        rst = 0; mem_ack = 1; mem_rdata = 32'h12345678;
        @(posedge clk); @(negedge clk);
        mem_ack = 0;
        check("late_ack_mem_req", mem_req, 0);
        check("late_ack_acks", {i_ack, d_ack}, 2'b00);
        @(posedge clk); #1;
        check("late_ack_acks2", {i_ack, d_ack}, 2'b00);
        check("late_ack_rdata", i_rdata, 0);
        last_d = 0; exp_ir = '0; exp_dr = '0;

        run_random(40);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, width of addresses, read data and write data.
REQ-002 Ports: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 Ports: rst  input  1  asynchronous, active-high reset.
REQ-004 Ports: i_req  input  1  fetch request; i_addr  input  DATA_WIDTH  fetch address; both held stable until i_ack.
REQ-005 Ports: d_req  input  1  data request; d_we  input  1  write enable; d_addr, d_wdata  input  DATA_WIDTH; d_size  input  3  load/store type code; all held stable until d_ack.
REQ-006 Ports: flush_i  input  1  discard any in-flight fetch (redirect or mispredict).
REQ-007 Ports: mem_req  output  1; mem_we  output  1; mem_addr, mem_wdata  output  DATA_WIDTH; mem_size  output  3; driven to the shared single-port memory.
REQ-008 Ports: mem_ack  input  1  memory completion pulse; mem_rdata  input  DATA_WIDTH  valid with mem_ack.
REQ-009 Ports: i_ack, d_ack  output  1  one-cycle completion pulses; i_rdata, d_rdata  output  DATA_WIDTH  valid while the matching ack is high.
REQ-010 Ports: i_stall, d_stall  output  1  pipeline hold, combinational: i_stall = i_req & ~i_ack, d_stall = d_req & ~d_ack.

Function
REQ-011 FSM states: IDLE, BUSY, RESP; owner register records I or D for the current transaction.
REQ-012 In IDLE with any request: grant one requester, latch its address, data, we and size into mem_* registers, set owner, go to BUSY.
REQ-013 Fetch mem_we SHALL be 0 and mem_size SHALL be 3'b010 (word); a data grant copies d_we and d_size.
REQ-014 In BUSY, mem_req SHALL be 1 and mem_* SHALL stay constant until mem_ack.
REQ-015 BUSY plus mem_ack: register mem_rdata into the owner's rdata output, deassert mem_req, go to RESP.
REQ-016 In RESP, pulse the owner's ack for exactly one cycle, then go to IDLE; requests are not sampled in RESP.
REQ-017 Minimum latency: request seen at edge N, mem_req high in cycle N+1, ack in cycle N+2 if mem_ack arrives in cycle N+1.
REQ-018 A requester SHALL drop req in its ack cycle or issue a new request there; a req still high in IDLE is a new transaction.
REQ-019 mem_ack outside BUSY SHALL be ignored.
REQ-020 flush_i while owner=I in BUSY: the memory transaction completes, then i_ack is suppressed and rdata is not updated; the FSM still passes through RESP.
REQ-021 flush_i while owner=I in RESP: suppress i_ack.
REQ-022 flush_i in IDLE: the fetch is not granted that cycle.
REQ-023 flush_i SHALL never affect data transactions.
REQ-024 i_rdata and d_rdata SHALL hold their value between transactions.

Reset
REQ-025 rst SHALL force immediately, without waiting for clk: state=IDLE, owner=I, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_size=0, i_ack=0, d_ack=0, i_rdata=0, d_rdata=0, last_grant=I.
REQ-026 rst during BUSY abandons the transaction; a late mem_ack after reset release is ignored per REQ-019.

Configuration
REQ-027 Macro MEM_ARB_RR_EN defined: on simultaneous i_req and d_req in IDLE, grant the requester not named by last_grant; last_grant updates on every grant; first conflict after reset goes to D.
REQ-028 Macro MEM_ARB_RR_EN undefined: on any conflict D always wins; the last_grant register is absent.

Verification
REQ-029 Single fetch: i_req=1, i_addr=0x100; mem_ack in the first BUSY cycle with rdata=0x00500093 -> mem_req high one cycle, i_ack two cycles after the request edge, i_rdata=0x00500093.
REQ-030 Store: d_req=1, d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF, d_size=3'b010, mem_ack after 3 wait cycles -> mem_* stable for 4 cycles, d_ack pulses once, i_ack stays 0.
REQ-031 Conflict: i_req and d_req both high for 3 back-to-back transactions -> RR_EN grants D,I,D; without RR_EN grants D,D,D with i_stall held high.
REQ-032 Flush: fetch to 0x104 in BUSY, flush_i pulsed, mem_ack with 0x12345678 -> no i_ack, i_rdata unchanged, FSM returns to IDLE.
REQ-033 Reset mid-BUSY: assert rst between clock edges -> mem_req drops with no clock edge; a mem_ack after release produces no ack.
